// File: rtl/systolic_seq_pkg.sv
// Shared types and sizing helpers for the systolic array tile sequencer.
// Used by systolic_array_sequencer and systolic_skew_decoder.
package systolic_seq_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CLEAR,
      ST_FEED,
      ST_DRAIN,
      ST_DONE
   } seq_state_e;

   // Final drain step for a tile of inner dimension k.
   function automatic longint s_end(longint k, int rows, int cols, int node_lat);
      return k + longint'(rows) + longint'(cols) - 64'sd3 + longint'(node_lat);
   endfunction

   // Step at which the last operand pair enters the array edge.
   function automatic longint feed_end(longint k, int rows, int cols);
      return k + longint'((rows > cols) ? rows : cols) - 64'sd2;
   endfunction

   // Step counter width that holds s_end at the largest K without wrapping.
   function automatic int step_width(int k_w, int rows, int cols, int node_lat);
      longint worst;
      worst = s_end((64'sd1 <<< k_w) - 64'sd1, rows, cols, node_lat);
      return $clog2(worst + 64'sd1);
   endfunction

endpackage

// File: rtl/systolic_array_sequencer_skew_decoder.sv
// Combinational diagonal-skew decode: lane i is valid while
// i <= step < i + k, gated by enable.
module systolic_skew_decoder
   import systolic_seq_pkg::*;
#(
   parameter int LANES  = 4,
   parameter int STEP_W = 8,
   parameter int K_W    = 8
) (
   input  logic [STEP_W-1:0] step,
   input  logic [K_W-1:0]    k,
   input  logic              enable,
   output logic [LANES-1:0]  valids
);

   localparam int W = STEP_W + 1;

   logic [W-1:0] step_x;
   logic [W-1:0] k_x;

   assign step_x = {1'b0, step};
   assign k_x    = W'(k);

   always_comb begin
      valids = '0;
      for (int i = 0; i < LANES; i++) begin
         valids[i] = enable && (step_x >= W'(i)) && (step_x < (W'(i) + k_x));
      end
   end

endmodule

// File: rtl/systolic_array_sequencer.sv
// Tile sequencer for one systolic MAC array: CLEAR, skewed FEED, DRAIN, DONE.
// Optional SEQ_CYCLE_CNT_EN adds Last_Cycles (accept-to-Done cycle count).
module systolic_array_sequencer
   import systolic_seq_pkg::*;
#(
   parameter int  ROWS         = 64,
   parameter int  COLUMNS      = 64,
   parameter int  K_W          = 16,
   parameter int  NODE_LATENCY = 1,
   localparam int STEP_W       = step_width(K_W, ROWS, COLUMNS, NODE_LATENCY)
) (
   input  logic               Clock,
   input  logic               Reset,
   input  logic               Start,
   output logic               Start_Ready,
   input  logic [K_W-1:0]     K_Len,
   output logic [STEP_W-1:0]  Step,
   output logic [COLUMNS-1:0] Act_Valids,
   output logic [ROWS-1:0]    Weight_Valids,
   output logic [ROWS-1:0]    Clear_Row,
   output logic [COLUMNS-1:0] Clear_Column,
   output logic               Busy,
   output logic               Done
`ifdef SEQ_CYCLE_CNT_EN
   ,output logic [31:0]       Last_Cycles
`endif
);

   localparam int W = STEP_W + 1;
   // Biases let both end tests be done as unsigned sums without negative offsets.
   localparam int FEED_BIAS = int'(feed_end(64'sd0, ROWS, COLUMNS)) + 2;
   localparam int S_BIAS    = int'(s_end(64'sd0, ROWS, COLUMNS, NODE_LATENCY)) + 3;

   seq_state_e        state;
   seq_state_e        state_nx;
   logic [K_W-1:0]    k_q;
   logic [STEP_W-1:0] step_q;
   logic [STEP_W-1:0] step_nx;
   logic              accept;
   logic              feed_last;
   logic              drain_last;
   logic              clear_all;
   logic              feed_en;
   logic [W-1:0]      step_ext;
   logic [W-1:0]      k_ext;

   assign accept     = Start && (state == ST_IDLE);
   assign step_ext   = {1'b0, step_q};
   assign k_ext      = W'(k_q);
   assign feed_last  = (step_ext + W'(2)) == (k_ext + W'(FEED_BIAS));
   assign drain_last = (step_ext + W'(3)) == (k_ext + W'(S_BIAS));

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE:  if (accept) state_nx = ST_CLEAR;
         ST_CLEAR: state_nx = (k_q == '0) ? ST_DONE : ST_FEED;
         ST_FEED: begin
            if (drain_last)     state_nx = ST_DONE;
            else if (feed_last) state_nx = ST_DRAIN;
         end
         ST_DRAIN: if (drain_last) state_nx = ST_DONE;
         ST_DONE:  state_nx = ST_IDLE;
         default:  state_nx = ST_IDLE;
      endcase
   end

   always_comb begin
      Start_Ready = (state == ST_IDLE);
      Busy        = (state != ST_IDLE);
      Done        = (state == ST_DONE);
      clear_all   = (state == ST_CLEAR);
      feed_en     = (state == ST_FEED);
   end

   // Step holds its final value through DONE, then returns to zero.
   always_comb begin
      step_nx = '0;
      case (state)
         ST_FEED, ST_DRAIN: step_nx = (state_nx == ST_DONE) ? step_q : step_q + STEP_W'(1);
         ST_DONE:           step_nx = '0;
         default:           step_nx = '0;
      endcase
   end

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         step_q <= '0;
         k_q    <= '0;
      end else begin
         step_q <= step_nx;
         if (accept) k_q <= K_Len;
      end
   end

   assign Step         = step_q;
   assign Clear_Row    = {ROWS{clear_all}};
   assign Clear_Column = {COLUMNS{clear_all}};

   systolic_skew_decoder #(
      .LANES  (COLUMNS),
      .STEP_W (STEP_W),
      .K_W    (K_W)
   ) u_col_dec (
      .step   (step_q),
      .k      (k_q),
      .enable (feed_en),
      .valids (Act_Valids)
   );

   systolic_skew_decoder #(
      .LANES  (ROWS),
      .STEP_W (STEP_W),
      .K_W    (K_W)
   ) u_row_dec (
      .step   (step_q),
      .k      (k_q),
      .enable (feed_en),
      .valids (Weight_Valids)
   );

`ifdef SEQ_CYCLE_CNT_EN
   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == '1) ? v : v + 32'd1;
   endfunction

   logic [31:0] cyc_q;

   // Value 2 on entering CLEAR accounts for the accept cycle and CLEAR itself.
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         cyc_q       <= '0;
         Last_Cycles <= '0;
      end else begin
         if (accept) cyc_q <= 32'd2;
         else        cyc_q <= sat_inc(cyc_q);
         if (state == ST_DONE) Last_Cycles <= cyc_q;
      end
   end
`endif

endmodule

// File: doc/systolic_array_sequencer.md
# systolic_array_sequencer

Tile-level controller that drives one systolic MAC array through a single matrix-tile computation. It accepts a start command with inner dimension K, clears all PE accumulators, generates the diagonally skewed activation/weight valid strobes plus a shared step index for the operand buffers, waits for the wavefront to drain, then pulses Done. It sits between the tile scheduler and the array; operand buffers use Step minus lane index as their read address.

## Interface
- ROWS, 64, array rows (weight lanes)
- COLUMNS, 64, array columns (activation lanes)
- K_W, 16, width of K_Len
- NODE_LATENCY, 1, cycles from last operand pair at a PE to its accumulator update
- Clock  in  1  rising-edge clock
- Reset  in  1  asynchronous, active-low reset
- Start  in  1  command valid
- Start_Ready  out  1  high only in IDLE
- K_Len  in  K_W  inner dimension; sampled on accept
- Step  out  STEP_W  feed/drain step index (package function of K_W, ROWS, COLUMNS, NODE_LATENCY)
- Act_Valids  out  [COLUMNS]  per-column activation valid, to array top edge
- Weight_Valids  out  [ROWS]  per-row weight valid, to array left edge
- Clear_Row  out  [ROWS]  accumulator clear, row mask
- Clear_Column  out  [COLUMNS]  accumulator clear, column mask
- Busy  out  1  state != IDLE
- Done  out  1  one-cycle completion pulse

## Operation
- States: IDLE, CLEAR, FEED, DRAIN, DONE.
- IDLE: Start_Ready=1; Start && Start_Ready accepts, latches K_Len, -> CLEAR. Start in any other state ignored, not queued.
- CLEAR (1 cycle): all Clear_Row and Clear_Column bits 1; Step=0. K=0 -> DONE; else -> FEED.
- FEED: Step increments by 1 per cycle from 0. Act_Valids[c] = (Step >= c) && (Step < c+K); Weight_Valids[r] likewise with r. -> DRAIN when Step = K+max(ROWS,COLUMNS)-2.
- DRAIN: Step keeps incrementing; all valids 0 (falls out of decode). -> DONE when Step = S_END = K+ROWS+COLUMNS-3+NODE_LATENCY.
- DONE (1 cycle): Done=1, Busy=1, Step holds; -> IDLE.
- All outputs are decodes of registered state/Step only; no combinational path from Start/K_Len to outputs.
- Step arithmetic unsigned, wide enough for S_END at K=2^K_W-1; no wrap.
- Clear masks are only ever all-ones or all-zeros.

## Timing
- Reset (async assert, sync deassert handled upstream): state IDLE, Step=0, all valids 0, clears 0, Busy=0, Done=0, Start_Ready=1, K latch 0.
- Reset mid-tile: immediate return to IDLE; no Done pulse; array state is caller's responsibility.
- Cycle 0 = accept edge. Cycle 1: CLEAR. Cycle 2+s: Step=s. Cycle 3+S_END: Done. Cycle 4+S_END: IDLE, Start_Ready=1; earliest next accept.
- K=0: CLEAR cycle 1, Done cycle 2, IDLE cycle 3.
- Back-to-back: Start held high re-accepts on first IDLE cycle.

## Configuration
- SEQ_CYCLE_CNT_EN defined: extra output Last_Cycles (32 bits, reset 0) loaded at DONE with cycles from accept edge through Done inclusive; free-running internal counter cleared on accept, saturates at all-ones.
- Undefined: port and counter absent; all other behaviour identical.

## Structure
- Package systolic_seq_pkg: state enum, STEP_W width function, S_END and feed-end helper functions.
- One sub-module systolic_skew_decoder (parameter LANES): combinational lane-valid decode from Step, K, enable; instantiated for rows and for columns.

## Test plan
- ROWS=COLUMNS=4, NODE_LATENCY=1, K=3, Start one cycle -> Clear all-ones cycle 1; Act_Valids[0] high Steps 0-2, [3] high Steps 3-5; S_END=9; Done cycle 12; Start_Ready cycle 13.
- K=0 -> Clear cycle 1, Done cycle 2, no valid ever asserted.
- Start pulsed during FEED -> ignored, Done count stays one; Start held continuously -> second accept on cycle 13, Clear cycle 14.
- Reset low at Step=4 -> all outputs reset values same cycle, no Done, next Start runs full sequence.
- ROWS=2, COLUMNS=6, K=1 -> Weight_Valids[1] only at Step 1, Act_Valids[5] only at Step 5, DRAIN entry at Step 5, S_END=7.
- SEQ_CYCLE_CNT_EN with 4x4 K=3 -> Last_Cycles=13 after Done; without macro build has no Last_Cycles port.
